// File: rtl/dac_spi_if.sv
// dac_spi_if: sample strobe handshake, status flags and DAC serial pins
interface dac_spi_if;
  logic [11:0] data_in;
  logic data_valid;
  logic busy;
  logic done;
  logic pending;
  logic dac_sclk;
  logic dac_sync_n;
  logic dac_din;
  modport master (output data_in, data_valid, input busy, done, pending, dac_sclk, dac_sync_n, dac_din);
  modport slave (input data_in, data_valid, output busy, done, pending, dac_sclk, dac_sync_n, dac_din);
endinterface

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: shifts 16-bit {CTRL, sample} frames MSB-first to a serial DAC, one-entry pending buffer
module dac_spi_tx #(
  parameter int CLK_DIV = 4,
  parameter logic [3:0] CTRL = 4'b0000
) (
  input logic clk,
  input logic rst_n,
  dac_spi_if.slave bus
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [4:0] half;
  logic [15:0] shreg;
  logic [11:0] pend_data;
  logic pend;
  logic tick;
  logic reload;
  assign tick = cnt == CW'(CLK_DIV - 1);
  // a strobe on the last gap cycle takes precedence over the buffered sample
  assign reload = state == GAP && tick && (pend || bus.data_valid);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = bus.data_valid ? SETUP : IDLE;
      SETUP: state_nxt = tick ? SHIFT : SETUP;
      SHIFT: state_nxt = (tick && half == 5'd31) ? GAP : SHIFT;
      GAP: state_nxt = tick ? (reload ? SETUP : IDLE) : GAP;
      default: state_nxt = IDLE;
    endcase
  end
  // half counts sclk half-periods in SHIFT: even = low, odd = high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      half <= '0;
      shreg <= '0;
      pend <= 1'b0;
      pend_data <= '0;
    end else begin
      cnt <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
      half <= state == SHIFT ? half + 5'(tick) : '0;
      if (state == IDLE && bus.data_valid) shreg <= {CTRL, bus.data_in};
      else if (reload) shreg <= {CTRL, bus.data_valid ? bus.data_in : pend_data};
      else if (state == SHIFT && tick && !half[0]) shreg <= {shreg[14:0], 1'b0};
      if (reload) pend <= 1'b0;
      else if (state != IDLE && bus.data_valid) begin
        pend <= 1'b1;
        pend_data <= bus.data_in;
      end
    end
  always_comb begin
    bus.busy = state != IDLE;
    bus.done = state == GAP && tick;
    bus.pending = pend;
    bus.dac_sync_n = !(state == SETUP || state == SHIFT);
    bus.dac_sclk = !(state == SHIFT && !half[0]);
    bus.dac_din = (state == SETUP || state == SHIFT) && shreg[15];
  end
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: scenario tasks checked against a frame-level timing model of the serializer
module tb_dac_spi_tx;
  localparam int D = 4;
  typedef struct {
    int start;
    int len;
    int falls;
    logic [15:0] val;
  } frame_t;
  logic clk = 0;
  logic rst_n = 1;
  int cyc = 0;
  int checks = 0;
  int errs = 0;
  frame_t fq0[$], fq1[$];
  int dq0[$], dq1[$];
  int sp[$];
  logic [11:0] sv[$];
  int es[$];
  logic [15:0] ev[$];
  dac_spi_if b0();
  dac_spi_if b1();
  dac_spi_tx #(.CLK_DIV(D), .CTRL(4'b0000)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  dac_spi_tx #(.CLK_DIV(1), .CTRL(4'b0001)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  bit ps[2] = '{1'b1, 1'b1};
  bit pc[2] = '{1'b1, 1'b1};
  bit inf[2] = '{1'b0, 1'b0};
  int st[2], ln[2], fl[2];
  logic [15:0] bt[2];
  // bus monitor: frames delimited by sync_n, din captured on each observed sclk fall
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic sy, sc, di, dn;
      frame_t f;
      sy = k ? b1.dac_sync_n : b0.dac_sync_n;
      sc = k ? b1.dac_sclk : b0.dac_sclk;
      di = k ? b1.dac_din : b0.dac_din;
      dn = k ? b1.done : b0.done;
      if (!sy && ps[k]) begin
        inf[k] = 1; st[k] = cyc; ln[k] = 0; fl[k] = 0; bt[k] = '0;
      end
      if (!sy) begin
        ln[k]++;
        if (pc[k] && !sc) begin
          fl[k]++;
          bt[k] = {bt[k][14:0], di};
        end
      end
      if (sy && !ps[k] && inf[k]) begin
        f.start = st[k]; f.len = ln[k]; f.falls = fl[k]; f.val = bt[k];
        if (k) fq1.push_back(f); else fq0.push_back(f);
        inf[k] = 0;
      end
      if (dn) begin
        if (k) dq1.push_back(cyc); else dq0.push_back(cyc);
      end
      ps[k] = sy;
      pc[k] = sc;
    end
  end
  // model: a frame loaded at cycle t ends at t+34d; strobes in (t, t+34d] are buffered, latest wins
  task automatic run_model(input int d, input logic [3:0] ctrl);
    int e;
    bit pd;
    logic [11:0] pv;
    es.delete(); ev.delete();
    e = -1000000; pd = 0; pv = '0;
    foreach (sp[i]) begin
      if (pd && e < sp[i]) begin
        es.push_back(e); ev.push_back({ctrl, pv}); e += 34 * d; pd = 0;
      end
      if (sp[i] > e) begin
        es.push_back(sp[i]); ev.push_back({ctrl, sv[i]}); e = sp[i] + 34 * d;
      end else begin
        pd = 1; pv = sv[i];
      end
    end
    if (pd) begin
      es.push_back(e); ev.push_back({ctrl, pv});
    end
  endtask
  task automatic clr;
    sp.delete(); sv.delete(); fq0.delete(); fq1.delete(); dq0.delete(); dq1.delete();
  endtask
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic strobe(input int k, input logic [11:0] v);
    if (k != 0) begin b1.data_valid = 1; b1.data_in = v; end
    else begin b0.data_valid = 1; b0.data_in = v; end
    sp.push_back(cyc + 1);
    sv.push_back(v);
    @(negedge clk);
    b0.data_valid = 0; b1.data_valid = 0;
    b0.data_in = 12'($urandom); b1.data_in = 12'($urandom);
  endtask
  task automatic wait_idle(input int k, output bit to);
    to = 1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (k != 0 ? (!b1.busy && !b1.pending) : (!b0.busy && !b0.pending)) begin
        to = 0;
        break;
      end
    end
    wait_cycles(3);
  endtask
  task automatic test_reset;
    b0.data_valid = 0; b1.data_valid = 0; b0.data_in = '0; b1.data_in = '0;
    #1 rst_n = 0;
    #1;
    checks++;
    if ({b0.busy, b0.done, b0.pending, b0.dac_sclk, b0.dac_sync_n, b0.dac_din} !== 6'b000110) begin
      errs++; $display("FAIL reset_dut0 got %b want 000110", {b0.busy, b0.done, b0.pending, b0.dac_sclk, b0.dac_sync_n, b0.dac_din});
    end
    checks++;
    if ({b1.busy, b1.done, b1.pending, b1.dac_sclk, b1.dac_sync_n, b1.dac_din} !== 6'b000110) begin
      errs++; $display("FAIL reset_dut1 got %b want 000110", {b1.busy, b1.done, b1.pending, b1.dac_sclk, b1.dac_sync_n, b1.dac_din});
    end
    wait_cycles(3);
    rst_n = 1;
    wait_cycles(5);
    checks++;
    if ({b0.busy, b0.dac_sync_n, b0.dac_sclk} !== 3'b011) begin
      errs++; $display("FAIL reset_release got %b want 011", {b0.busy, b0.dac_sync_n, b0.dac_sclk});
    end
  endtask
  task automatic test_single;
    bit to;
    clr();
    strobe(0, 12'hA5C);
    wait_idle(0, to);
    run_model(D, 4'h0);
    checks++; if (to) begin errs++; $display("FAIL single_timeout got busy want idle"); end
    checks++;
    if (fq0.size() != 1 || dq0.size() != 1) begin
      errs++; $display("FAIL single_count got frames=%0d dones=%0d want 1 1", fq0.size(), dq0.size());
    end else begin
      checks++;
      if (fq0[0].val !== 16'h0A5C || fq0[0].len != 33 * D || fq0[0].falls != 16 || fq0[0].start != es[0] || dq0[0] != es[0] + 34 * D - 1) begin
        errs++; $display("FAIL single_frame got val=%h len=%0d falls=%0d start=%0d done=%0d want val=0a5c len=%0d falls=16 start=%0d done=%0d",
          fq0[0].val, fq0[0].len, fq0[0].falls, fq0[0].start, dq0[0], 33 * D, es[0], es[0] + 34 * D - 1);
      end
    end
  endtask
  task automatic test_back_to_back;
    bit to;
    int p;
    clr();
    strobe(0, 12'h123);
    p = cyc;
    wait_cycles(49);
    strobe(0, 12'h456);
    checks++; if (b0.pending !== 1'b1) begin errs++; $display("FAIL b2b_pending_set got %b want 1", b0.pending); end
    wait_cycles(p + 34 * D - 1 - cyc);
    checks++; if ({b0.pending, b0.done} !== 2'b11) begin errs++; $display("FAIL b2b_pending_at_done got %b want 11", {b0.pending, b0.done}); end
    wait_cycles(1);
    checks++; if ({b0.pending, b0.busy, b0.dac_sync_n} !== 3'b010) begin errs++; $display("FAIL b2b_restart got %b want 010", {b0.pending, b0.busy, b0.dac_sync_n}); end
    wait_idle(0, to);
    run_model(D, 4'h0);
    checks++; if (to || fq0.size() != es.size() || dq0.size() != es.size()) begin
      errs++; $display("FAIL b2b_count got frames=%0d dones=%0d want %0d", fq0.size(), dq0.size(), es.size());
    end
    foreach (es[i]) if (i < fq0.size() && i < dq0.size()) begin
      checks++;
      if (fq0[i].val !== ev[i] || fq0[i].start != es[i] || fq0[i].len != 33 * D || fq0[i].falls != 16 || dq0[i] != es[i] + 34 * D - 1) begin
        errs++; $display("FAIL b2b_frame%0d got val=%h start=%0d len=%0d done=%0d want val=%h start=%0d len=%0d done=%0d",
          i, fq0[i].val, fq0[i].start, fq0[i].len, dq0[i], ev[i], es[i], 33 * D, es[i] + 34 * D - 1);
      end
    end
  endtask
  task automatic test_overwrite;
    bit to;
    clr();
    strobe(0, 12'h001);
    wait_cycles(20);
    strobe(0, 12'h002);
    wait_cycles(20);
    strobe(0, 12'h003);
    wait_idle(0, to);
    wait_cycles(200);
    run_model(D, 4'h0);
    checks++; if (to || fq0.size() != 2 || es.size() != 2) begin
      errs++; $display("FAIL ovw_count got frames=%0d want 2", fq0.size());
    end else begin
      checks++;
      if (fq0[1].val !== 16'h0003 || fq0[1].start != es[1]) begin
        errs++; $display("FAIL ovw_frame2 got val=%h start=%0d want val=0003 start=%0d", fq0[1].val, fq0[1].start, es[1]);
      end
    end
  endtask
  task automatic test_coincide;
    bit to;
    int p;
    clr();
    strobe(0, 12'h321);
    p = cyc;
    wait_cycles(34 * D - 1);
    checks++; if (b0.done !== 1'b1) begin errs++; $display("FAIL coin_done got %b want 1", b0.done); end
    strobe(0, 12'hFFF);
    checks++; if ({b0.busy, b0.dac_sync_n} !== 2'b10) begin errs++; $display("FAIL coin_no_idle got %b want 10", {b0.busy, b0.dac_sync_n}); end
    wait_idle(0, to);
    run_model(D, 4'h0);
    checks++; if (to || fq0.size() != 2 || es.size() != 2) begin
      errs++; $display("FAIL coin_count got frames=%0d want 2", fq0.size());
    end else begin
      checks++;
      if (fq0[1].val !== 16'h0FFF || fq0[1].start != p + 34 * D || fq0[1].falls != 16) begin
        errs++; $display("FAIL coin_frame2 got val=%h start=%0d falls=%0d want val=0fff start=%0d falls=16", fq0[1].val, fq0[1].start, fq0[1].falls, p + 34 * D);
      end
    end
  endtask
  task automatic test_reset_mid;
    clr();
    strobe(0, 12'h5A5);
    wait_cycles(20);
    strobe(0, 12'h777);
    wait_cycles(37);
    checks++; if (b0.pending !== 1'b1) begin errs++; $display("FAIL rst_pending_before got %b want 1", b0.pending); end
    #1 rst_n = 0;
    #1;
    checks++;
    if ({b0.dac_sync_n, b0.dac_sclk, b0.busy, b0.pending, b0.done} !== 5'b11000) begin
      errs++; $display("FAIL rst_mid got %b want 11000", {b0.dac_sync_n, b0.dac_sclk, b0.busy, b0.pending, b0.done});
    end
    wait_cycles(3);
    rst_n = 1;
    wait_cycles(300);
    checks++;
    if (fq0.size() != 1 || dq0.size() != 0 || b0.busy !== 1'b0) begin
      errs++; $display("FAIL rst_no_resume got frames=%0d dones=%0d busy=%b want 1 0 0", fq0.size(), dq0.size(), b0.busy);
    end else begin
      checks++;
      if (fq0[0].falls >= 16) begin errs++; $display("FAIL rst_aborted_falls got %0d want <16", fq0[0].falls); end
    end
  endtask
  task automatic test_div1;
    bit to;
    clr();
    strobe(1, 12'h800);
    wait_idle(1, to);
    run_model(1, 4'h1);
    checks++;
    if (to || fq1.size() != 1 || dq1.size() != 1) begin
      errs++; $display("FAIL div1_count got frames=%0d dones=%0d want 1 1", fq1.size(), dq1.size());
    end else begin
      checks++;
      if (fq1[0].val !== 16'h1800 || fq1[0].len != 33 || fq1[0].falls != 16 || fq1[0].start != es[0] || dq1[0] != es[0] + 33) begin
        errs++; $display("FAIL div1_frame got val=%h len=%0d falls=%0d start=%0d done=%0d want val=1800 len=33 falls=16 start=%0d done=%0d",
          fq1[0].val, fq1[0].len, fq1[0].falls, fq1[0].start, dq1[0], es[0], es[0] + 33);
      end
    end
  endtask
  task automatic test_random;
    bit to;
    clr();
    for (int i = 0; i < 24; i++) begin
      strobe(0, 12'($urandom));
      wait_cycles($urandom_range(1, 180));
    end
    wait_idle(0, to);
    run_model(D, 4'h0);
    checks++; if (to || fq0.size() != es.size() || dq0.size() != es.size()) begin
      errs++; $display("FAIL rand_count got frames=%0d dones=%0d want %0d", fq0.size(), dq0.size(), es.size());
    end
    foreach (es[i]) if (i < fq0.size() && i < dq0.size()) begin
      checks++;
      if (fq0[i].val !== ev[i] || fq0[i].start != es[i] || fq0[i].len != 33 * D || fq0[i].falls != 16 || dq0[i] != es[i] + 34 * D - 1) begin
        errs++; $display("FAIL rand_frame%0d got val=%h start=%0d len=%0d falls=%0d done=%0d want val=%h start=%0d len=%0d falls=16 done=%0d",
          i, fq0[i].val, fq0[i].start, fq0[i].len, fq0[i].falls, dq0[i], ev[i], es[i], 33 * D, es[i] + 34 * D - 1);
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overwrite();
    test_coincide();
    test_reset_mid();
    test_div1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
